// File: rtl/pc_fetch_unit_if.sv
// Fetch-address bus between the PC stage and instruction memory.
// The PC stage is the master; instruction memory answers with if_ready.
interface pc_fetch_unit_if;
  logic [31:0] if_addr;
  logic        if_valid;
  logic        if_ready;

  modport master (output if_addr, output if_valid, input if_ready);
  modport slave  (input if_addr, input if_valid, output if_ready);
endinterface

// File: rtl/pc_fetch_unit.sv
// MIPS PC / next-address stage: holds the PC, forms branch and jump targets,
// and keeps one taken redirect buffered while fetch is blocked.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            branch_offset,
  input  logic [31:0]            branch_pc,
  input  logic                   branch_taken,
  input  logic                   jump,
  input  logic [25:0]            jump_index,
  input  logic                   stall,
  pc_fetch_unit_if.master        fetch,
  output logic [31:0]            pc_plus4,
  output logic                   redirected
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] pend_addr, pend_nx;
  logic        redir_nx;
  logic        valid;
  logic        fire;
  logic        req;
  logic [31:0] target;

  assign valid = (state != BOOT);
  assign fire  = valid & fetch.if_ready & ~stall;
  assign req   = jump | branch_taken;
  // Jump has priority over a simultaneously taken branch.
  assign target = jump ? {branch_pc[31:28], jump_index, 2'b00}
                       : branch_pc + branch_offset;

  assign fetch.if_addr  = pc;
  assign fetch.if_valid = valid;
  assign pc_plus4       = pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      pend_addr  <= '0;
      redirected <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      pend_addr  <= pend_nx;
      redirected <= redir_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    pend_nx  = pend_addr;
    redir_nx = 1'b0;
    case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (fire) begin
          if (req) begin
            pc_nx    = target;
            redir_nx = 1'b1;
          end else begin
            pc_nx = pc + 32'd4;
          end
        end else if (req) begin
          pend_nx  = target;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        // A newer request supersedes the buffered one.
        if (fire) begin
          pc_nx    = req ? target : pend_addr;
          redir_nx = 1'b1;
          state_nx = RUN;
        end else if (req) begin
          pend_nx = target;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus random
// stimulus compared every cycle against a behavioural model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] branch_offset;
  logic [31:0] branch_pc;
  logic        branch_taken;
  logic        jump;
  logic [25:0] jump_index;
  logic        stall;
  logic [31:0] pc_plus4;
  logic        redirected;

  pc_fetch_unit_if fetch ();

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_offset(branch_offset),
    .branch_pc    (branch_pc),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_index   (jump_index),
    .stall        (stall),
    .fetch        (fetch),
    .pc_plus4     (pc_plus4),
    .redirected   (redirected)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: booting flag, PC, optional pending redirect, pulse.
  bit          m_boot;
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  bit          m_red;
  bit          chk_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] target_of(input logic j, input logic [31:0] bpc,
                                            input logic [31:0] off, input logic [25:0] idx);
    logic [31:0] t;
    if (j) t = {bpc[31:28], idx, 2'b00};
    else   t = bpc + off;
    return t;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1;
    m_pc   = RST_PC;
    m_pend.delete();
    m_red  = 1'b0;
  endtask

  task automatic model_step();
    bit          f;
    bit          r;
    logic [31:0] t;
    f = !m_boot && fetch.if_ready && !stall;
    r = jump || branch_taken;
    t = target_of(jump, branch_pc, branch_offset, jump_index);
    m_red = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (f) begin
      if (r) begin
        m_pc  = t;
        m_red = 1'b1;
      end else if (m_pend.size() > 0) begin
        m_pc  = m_pend.pop_front();
        m_red = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_pend.delete();
    end else if (r) begin
      m_pend.delete();
      m_pend.push_back(t);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check32("cmp_if_addr",    fetch.if_addr,         m_pc);
      check32("cmp_if_valid",   {31'b0, fetch.if_valid}, {31'b0, !m_boot});
      check32("cmp_pc_plus4",   pc_plus4,              m_pc + 32'd4);
      check32("cmp_redirected", {31'b0, redirected},   {31'b0, m_red});
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic bt, input logic j, input logic [31:0] bpc,
                       input logic [31:0] off, input logic [25:0] idx,
                       input logic rdy, input logic stl);
    branch_taken   = bt;
    jump           = j;
    branch_pc      = bpc;
    branch_offset  = off;
    jump_index     = idx;
    fetch.if_ready = rdy;
    stall          = stl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle, held across one rising edge.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check32("async_rst_addr",  fetch.if_addr, RST_PC);
    check32("async_rst_valid", {31'b0, fetch.if_valid}, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] held;
  logic [31:0] r32;

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    check32("reset_addr",   fetch.if_addr, RST_PC);
    check32("reset_valid",  {31'b0, fetch.if_valid}, 32'h0);
    check32("reset_redir",  {31'b0, redirected}, 32'h0);
    check32("reset_plus4",  pc_plus4, 32'h0040_0004);
    @(negedge clk);
    #1 rst = 1'b0;

    // Boot edge, then sequential fetch.
    cyc();
    check32("first_req_addr",  fetch.if_addr, 32'h0040_0000);
    check32("first_req_valid", {31'b0, fetch.if_valid}, 32'h1);
    cyc();
    check32("seq_addr_1", fetch.if_addr, 32'h0040_0004);
    cyc();
    check32("seq_addr_2", fetch.if_addr, 32'h0040_0008);

    // Jump to 0x100, then backward branch to 0x0F0.
    drive(1'b0, 1'b1, 32'h0, 32'h0, 26'h000_0040, 1'b1, 1'b0);
    cyc();
    check32("jump_0x100", fetch.if_addr, 32'h0000_0100);
    drive(1'b1, 1'b0, 32'h0000_0100, 32'hFFFF_FFF0, 26'h0, 1'b1, 1'b0);
    cyc();
    check32("branch_back_addr",  fetch.if_addr, 32'h0000_00F0);
    check32("branch_back_redir", {31'b0, redirected}, 32'h1);
    idle();
    cyc();
    check32("redir_pulse_end", {31'b0, redirected}, 32'h0);
    check32("after_branch_seq", fetch.if_addr, 32'h0000_00F4);

    // Jump wins over a simultaneous taken branch.
    drive(1'b1, 1'b1, 32'h9000_0010, 32'h0000_0040, 26'h000_0040, 1'b1, 1'b0);
    cyc();
    check32("jump_priority", fetch.if_addr, 32'h9000_0100);

    // Redirect resolved while fetch is blocked is buffered.
    drive(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0100, 26'h0, 1'b0, 1'b0);
    cyc();
    check32("blocked_hold_0", fetch.if_addr, 32'h9000_0100);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check32("blocked_hold", fetch.if_addr, 32'h9000_0100);
      check32("blocked_valid", {31'b0, fetch.if_valid}, 32'h1);
    end
    idle();
    cyc();
    check32("buffered_apply", fetch.if_addr, 32'h0000_0200);
    check32("buffered_redir", {31'b0, redirected}, 32'h1);

    // Stall with ready high keeps the PC.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check32("stall_addr",  fetch.if_addr, 32'h0000_0200);
      check32("stall_redir", {31'b0, redirected}, 32'h0);
    end

    // Reset while a redirect is pending discards it.
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0000_0020, 26'h0, 1'b0, 1'b0);
    cyc();
    idle();
    do_reset();
    cyc();
    check32("post_rst_addr", fetch.if_addr, RST_PC);
    cyc();
    check32("pend_discarded",       fetch.if_addr, 32'h0040_0004);
    check32("pend_discarded_redir", {31'b0, redirected}, 32'h0);

    // PC+4 wraps at the top of the address space.
    drive(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0000_0004, 26'h0, 1'b1, 1'b0);
    cyc();
    check32("top_addr",  fetch.if_addr, 32'hFFFF_FFFC);
    check32("top_plus4", pc_plus4, 32'h0000_0000);
    idle();
    cyc();
    check32("wrap_addr", fetch.if_addr, 32'h0000_0000);

    // Randomized traffic, including occasional mid-run resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        r32 = $urandom();
        r32[1:0] = 2'b00;
        held = $urandom();
        held[1:0] = 2'b00;
        drive($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 15, held, r32,
              26'($urandom()), $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20);
      end
      cyc();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
